// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the divide issue controller and the iterative divider.
// The controller drives operands/start/annul; the divider returns result/ready.
interface div_issue_ctrl_if;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    modport master (
        output div_signed_o,
        output div_op1_o,
        output div_op2_o,
        output div_start_o,
        output div_annul_o,
        input  div_result_i,
        input  div_ready_i
    );

    modport slave (
        input  div_signed_o,
        input  div_op1_o,
        input  div_op2_o,
        input  div_start_o,
        input  div_annul_o,
        output div_result_i,
        output div_ready_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the iterative divider: issues DIV/DIVU, stalls EX
// until the result returns, writes HI/LO once, and annuls the divider on flush.
module div_issue_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_div_valid_i,
    input  logic             ex_div_signed_i,
    input  logic [31:0]      ex_opa_i,
    input  logic [31:0]      ex_opb_i,
    input  logic             flush_i,
    output logic             stall_req_o,
    output logic             hilo_we_o,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    div_issue_ctrl_if.master div_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ABORT
    } state_e;

    // Cycles of annul needed to drain the divider from any of its states.
    localparam logic [1:0] ABORT_CYCLES = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  abort_cnt_q, abort_cnt_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        start_q, start_d;
    logic        annul_q, annul_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            abort_cnt_q <= 2'd0;
            signed_q    <= 1'b0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            start_q     <= 1'b0;
            annul_q     <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            abort_cnt_q <= abort_cnt_d;
            signed_q    <= signed_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            start_q     <= start_d;
            annul_q     <= annul_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        abort_cnt_d = abort_cnt_q;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        start_d     = start_q;
        annul_d     = annul_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        stall_req_o = 1'b0;
        hilo_we_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_req_o = ex_div_valid_i & ~flush_i;
                if (ex_div_valid_i && !flush_i) begin
                    signed_d = ex_div_signed_i;
                    op1_d    = ex_opa_i;
                    op2_d    = ex_opb_i;
                    start_d  = 1'b1;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                // Releasing the stall in the ready cycle lets the DIV leave EX
                // on the same edge that captures the result.
                stall_req_o = ~div_if.div_ready_i & ~flush_i;
                if (flush_i) begin
                    start_d     = 1'b0;
                    annul_d     = 1'b1;
                    abort_cnt_d = ABORT_CYCLES;
                    state_d     = S_ABORT;
                end else if (div_if.div_ready_i) begin
                    hi_d    = div_if.div_result_i[63:32];
                    lo_d    = div_if.div_result_i[31:0];
                    start_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                stall_req_o = ex_div_valid_i;
                hilo_we_o   = ~flush_i;
                state_d     = S_IDLE;
            end
            S_ABORT: begin
                stall_req_o = ex_div_valid_i;
                if (abort_cnt_q == 2'd1) begin
                    abort_cnt_d = 2'd0;
                    annul_d     = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    abort_cnt_d = abort_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi_o                = hi_q;
    assign lo_o                = lo_q;
    assign div_if.div_signed_o = signed_q;
    assign div_if.div_op1_o    = op1_q;
    assign div_if.div_op2_o    = op2_q;
    assign div_if.div_start_o  = start_q;
    assign div_if.div_annul_o  = annul_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: a behavioural divider drives the
// handshake, a timestamp-based model predicts every output, directed runs pin timing.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        sgn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        stall;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    div_issue_ctrl_if dif ();

    div_issue_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ex_div_valid_i  (valid),
        .ex_div_signed_i (sgn),
        .ex_opa_i        (opa),
        .ex_opb_i        (opb),
        .flush_i         (flush),
        .stall_req_o     (stall),
        .hilo_we_o       (hilo_we),
        .hi_o            (hi),
        .lo_o            (lo),
        .div_if          (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural divide: truncating quotient, remainder takes dividend sign,
    // divide-by-zero yields zeros.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural divider: 35 edges of start for nonzero divisor, 3 for zero.
    int dv_state = 0;
    int dv_cnt = 0;
    always @(posedge clk) begin
        if (rst || dif.div_annul_o || !dif.div_start_o) begin
            dv_state         <= 0;
            dif.div_ready_i  <= 1'b0;
            dif.div_result_i <= 64'd0;
        end else if (dv_state == 0) begin
            dv_state <= 1;
            dv_cnt   <= (dif.div_op2_o == 32'd0) ? 1 : 33;
        end else if (dv_state == 1) begin
            if (dv_cnt == 0) begin
                dv_state         <= 2;
                dif.div_ready_i  <= 1'b1;
                dif.div_result_i <= ref_div(dif.div_signed_o, dif.div_op1_o, dif.div_op2_o);
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    // Reference model: what the controller must be doing is derived from when
    // the current DIV was accepted, when its result arrived and when a flush hit.
    int          cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_done_at = -10;
    int          m_abort_end = -10;
    logic        m_sg = 1'b0;
    logic [31:0] m_op1 = 32'd0;
    logic [31:0] m_op2 = 32'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic bit m_idle();
        return !m_busy && (cyc != m_done_at) && (cyc > m_abort_end);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid     = 1'b1;
            m_busy      = 1'b0;
            m_done_at   = -10;
            m_abort_end = -10;
            m_sg        = 1'b0;
            m_op1       = 32'd0;
            m_op2       = 32'd0;
            m_hi        = 32'd0;
            m_lo        = 32'd0;
        end else if (m_idle() && valid && !flush) begin
            m_busy = 1'b1;
            m_sg   = sgn;
            m_op1  = opa;
            m_op2  = opb;
        end else if (m_busy && flush) begin
            m_busy      = 1'b0;
            m_abort_end = cyc + 3;
        end else if (m_busy && dif.div_ready_i) begin
            m_busy       = 1'b0;
            m_done_at    = cyc + 1;
            {m_hi, m_lo} = ref_div(m_sg, m_op1, m_op2);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit in_done, in_abort, idle, e_stall, e_we;
            in_done  = (cyc == m_done_at);
            in_abort = (cyc <= m_abort_end);
            idle     = !m_busy && !in_done && !in_abort;
            e_stall  = (idle && valid && !flush) || (m_busy && !dif.div_ready_i && !flush)
                       || ((in_done || in_abort) && valid);
            e_we     = in_done && !flush;
            check("stall_req_o", 64'(stall), 64'(e_stall));
            check("hilo_we_o", 64'(hilo_we), 64'(e_we));
            check("hi_o", 64'(hi), 64'(m_hi));
            check("lo_o", 64'(lo), 64'(m_lo));
            check("div_start_o", 64'(dif.div_start_o), 64'(m_busy));
            check("div_annul_o", 64'(dif.div_annul_o), 64'(in_abort));
            check("div_signed_o", 64'(dif.div_signed_o), 64'(m_sg));
            check("div_op1_o", 64'(dif.div_op1_o), 64'(m_op1));
            check("div_op2_o", 64'(dif.div_op2_o), 64'(m_op2));
        end
    end

    // Directed-run bookkeeping; cycle 0 is the first cycle the DIV is in EX.
    logic        ops_sg[2];
    logic [31:0] ops_a[2];
    logic [31:0] ops_b[2];
    int          we_cyc[$];
    logic [31:0] we_hi[$];
    logic [31:0] we_lo[$];
    int          start_rise[$];
    int          ready_rise[$];
    int          stall_cycles;

    task automatic run_ops(input int n, input int ncyc);
        int   idx;
        logic st, prev_start, prev_ready;
        idx = 0;
        prev_start = 1'b0;
        prev_ready = 1'b0;
        stall_cycles = 0;
        we_cyc.delete(); we_hi.delete(); we_lo.delete();
        start_rise.delete(); ready_rise.delete();
        @(posedge clk); #1;
        valid = 1'b1; sgn = ops_sg[0]; opa = ops_a[0]; opb = ops_b[0];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            st = stall;
            if (valid && st) stall_cycles++;
            if (hilo_we) begin
                we_cyc.push_back(c); we_hi.push_back(hi); we_lo.push_back(lo);
            end
            if (dif.div_start_o && !prev_start) start_rise.push_back(c);
            if (dif.div_ready_i && !prev_ready) ready_rise.push_back(c);
            prev_start = dif.div_start_o;
            prev_ready = dif.div_ready_i;
            @(posedge clk); #1;
            if (valid && !st) begin
                idx++;
                if (idx < n) begin
                    sgn = ops_sg[idx]; opa = ops_a[idx]; opb = ops_b[idx];
                end else begin
                    valid = 1'b0;
                end
            end
        end
    endtask

    task automatic single(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int e_stall, input int e_we, input logic [31:0] e_hi, input logic [31:0] e_lo);
        ops_sg[0] = s; ops_a[0] = a; ops_b[0] = b;
        run_ops(1, 45);
        check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(e_stall));
        check({tag, "_we_count"}, 64'(we_cyc.size()), 64'd1);
        if (start_rise.size() > 0) check({tag, "_start_cycle"}, 64'(start_rise[0]), 64'd1);
        if (ready_rise.size() > 0) check({tag, "_ready_cycle"}, 64'(ready_rise[0]), 64'(e_stall));
        if (we_cyc.size() > 0) begin
            check({tag, "_we_cycle"}, 64'(we_cyc[0]), 64'(e_we));
            check({tag, "_hi"}, 64'(we_hi[0]), 64'(e_hi));
            check({tag, "_lo"}, 64'(we_lo[0]), 64'(e_lo));
        end
    endtask

    task automatic run_flush();
        logic st;
        int   n_we, we_at, acc_stall;
        logic [31:0] w_hi, w_lo;
        n_we = 0; we_at = -1; acc_stall = 0; w_hi = 32'd0; w_lo = 32'd0;
        @(posedge clk); #1;
        valid = 1'b1; sgn = 1'b0; opa = 32'd1000; opb = 32'd3;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            st = stall;
            if (c >= 11 && c <= 13) begin
                check("flush_start_low", 64'(dif.div_start_o), 64'd0);
                check("flush_annul_high", 64'(dif.div_annul_o), 64'd1);
                check("flush_stall_waiting_div", 64'(stall), 64'd1);
            end
            if (c == 14) begin
                check("flush_annul_released", 64'(dif.div_annul_o), 64'd0);
                acc_stall = int'(stall);
            end
            if (c == 15) begin
                check("flush_restart", 64'(dif.div_start_o), 64'd1);
                check("flush_new_op1", 64'(dif.div_op1_o), 64'hFFFF_FFB3);
            end
            if (hilo_we) begin
                n_we++; we_at = c; w_hi = hi; w_lo = lo;
            end
            @(posedge clk); #1;
            if (c == 9) flush = 1'b1;
            if (c == 10) begin
                flush = 1'b0; sgn = 1'b1; opa = 32'hFFFF_FFB3; opb = 32'd5;
            end
            if (c >= 11 && valid && !st) valid = 1'b0;
        end
        check("flush_accept_stall", 64'(acc_stall), 64'd1);
        check("flush_we_count", 64'(n_we), 64'd1);
        check("flush_we_cycle", 64'(we_at), 64'd51);
        check("flush_hi", 64'(w_hi), 64'hFFFF_FFFE);
        check("flush_lo", 64'(w_lo), 64'hFFFF_FFF1);
    endtask

    task automatic run_reset();
        int n_we;
        n_we = 0;
        @(posedge clk); #1;
        valid = 1'b1; sgn = 1'b0; opa = 32'd1234; opb = 32'd5;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 21) begin
                check("rst_stall", 64'(stall), 64'd0);
                check("rst_hilo_we", 64'(hilo_we), 64'd0);
                check("rst_hi_lo", {hi, lo}, 64'd0);
                check("rst_start_annul", 64'({dif.div_start_o, dif.div_annul_o}), 64'd0);
                check("rst_operands", {dif.div_op1_o, dif.div_op2_o}, 64'd0);
                check("rst_signed", 64'(dif.div_signed_o), 64'd0);
            end
            if (c >= 20 && hilo_we) n_we++;
            @(posedge clk); #1;
            if (c == 19) begin rst = 1'b1; valid = 1'b0; end
            if (c == 20) rst = 1'b0;
        end
        check("rst_no_we", 64'(n_we), 64'd0);
    endtask

    function automatic logic [31:0] rand_opnd(input bit divisor);
        int sel;
        sel = int'($urandom_range(0, 9));
        if (divisor && sel < 2) return 32'd0;
        if (sel < 5) return 32'($urandom_range(1, 20));
        if (sel < 7) return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        return 32'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic keep;
        check("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        check("model_div_m100_7", ref_div(1'b1, 32'hFFFF_FF9C, 32'd7), 64'hFFFF_FFFE_FFFF_FFF2);
        check("model_div_5_0", ref_div(1'b1, 32'd5, 32'd0), 64'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        single("divu_100_7", 1'b0, 32'd100, 32'd7, 36, 37, 32'd2, 32'd14);
        single("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 36, 37, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        single("div_5_0", 1'b1, 32'd5, 32'd0, 4, 5, 32'd0, 32'd0);

        run_flush();

        ops_sg[0] = 1'b0; ops_a[0] = 32'd9; ops_b[0] = 32'd2;
        ops_sg[1] = 1'b0; ops_a[1] = 32'd9; ops_b[1] = 32'd4;
        run_ops(2, 85);
        check("b2b_we_count", 64'(we_cyc.size()), 64'd2);
        check("b2b_start_count", 64'(start_rise.size()), 64'd2);
        if (we_cyc.size() == 2) begin
            check("b2b_we0_cycle", 64'(we_cyc[0]), 64'd37);
            check("b2b_we0_hilo", {we_hi[0], we_lo[0]}, {32'd1, 32'd4});
            check("b2b_we1_cycle", 64'(we_cyc[1]), 64'd75);
            check("b2b_we1_hilo", {we_hi[1], we_lo[1]}, {32'd1, 32'd2});
        end
        if (start_rise.size() == 2) check("b2b_second_start", 64'(start_rise[1]), 64'd39);

        run_reset();

        // Randomized traffic: a stalled DIV stays in EX unless flushed.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            keep = valid && stall && !flush && !rst;
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 599) == 0);
            flush = ($urandom_range(0, 99) < 3);
            if (!keep) begin
                valid = ($urandom_range(0, 9) < 6);
                sgn   = 1'($urandom_range(0, 1));
                opa   = rand_opnd(1'b0);
                opb   = rand_opnd(1'b1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage initiator for the iterative 32-bit divider. Accepts DIV/DIVU from EX, drives the divider's start/annul/operand handshake, and holds the pipeline stalled until the result returns. Delivers remainder/quotient as a one-cycle HI/LO write, and aborts cleanly on pipeline flush. Sits between the EX stage, the hazard/stall unit, and the divider.

## Interface
- Parameters: none; operand width fixed at 32.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_div_valid_i` in 1: EX currently holds a DIV/DIVU.
- `ex_div_signed_i` in 1: 1 = DIV (signed), 0 = DIVU.
- `ex_opa_i` in 32: dividend (rs).
- `ex_opb_i` in 32: divisor (rt).
- `flush_i` in 1: pipeline flush/exception; kills the in-flight division.
- `stall_req_o` out 1: stall request to the hazard unit (combinational).
- `hilo_we_o` out 1: HI/LO write enable, one-cycle pulse.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.
- `div_signed_o` out 1: to divider signed select (registered).
- `div_op1_o` out 32: to divider dividend (registered).
- `div_op2_o` out 32: to divider divisor (registered).
- `div_start_o` out 1: to divider start (registered).
- `div_annul_o` out 1: to divider annul (registered).
- `div_result_i` in 64: from divider; [63:32] remainder, [31:0] quotient.
- `div_ready_i` in 1: from divider; result valid, held until start drops.

## Operation
- Reset: state IDLE, abort counter 0, all registered outputs 0, hi_o/lo_o 0.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - If `ex_div_valid_i & ~flush_i`: latch signed/opa/opb into `div_*_o`, set `div_start_o`=1, go BUSY.
  - Otherwise stay in IDLE.
- BUSY: `div_start_o` stays 1 and operands stay stable.
  - If `flush_i` (takes priority over `div_ready_i`): `div_start_o`<=0, `div_annul_o`<=1, counter<=3, go ABORT. No HI/LO write.
  - Else if `div_ready_i`: capture hi_o/lo_o from `div_result_i`, `div_start_o`<=0, go DONE.
- DONE: lasts one cycle, then IDLE. `hilo_we_o` = DONE & ~`flush_i`.
- ABORT: `div_start_o`=0 and `div_annul_o`=1 for exactly 3 cycles (counter decrements to 0), then `div_annul_o`<=0 and go IDLE. Three cycles covers divider drain from any of its states: iterating, divide-by-zero, or result-held.
- `stall_req_o` = (IDLE & `ex_div_valid_i` & ~`flush_i`) | (BUSY & ~`div_ready_i` & ~`flush_i`) | ((DONE | ABORT) & `ex_div_valid_i`).
- A new division is accepted only in IDLE; DONE and ABORT stall a waiting DIV.
- Sign correction and divide-by-zero result (hi=0, lo=0) are produced by the divider; this block passes them through unmodified.
- Reset mid-operation: immediate return to reset values. The divider shares `rst`, so no drain is needed.

## Timing
- Cycle 0 = first cycle IDLE sees a valid DIV; `div_start_o` is high from cycle 1.
- Nonzero divisor:
  - `div_ready_i` first high in cycle 36.
  - `stall_req_o` high cycles 0–35 and low in cycle 36, so the instruction leaves EX at the cycle-36 edge.
  - DONE in cycle 37, with `hilo_we_o` high in cycle 37 only.
  - IDLE in cycle 38.
- Divisor zero: `div_ready_i` in cycle 4, stall cycles 0–3, `hilo_we_o` in cycle 5.
- `div_start_o` drops the cycle after ready is seen, which releases the divider to its free state one edge later.
- Back-to-back DIVs: earliest next acceptance is cycle 38, with start in cycle 39.

## Test plan
- DIVU 100/7 -> stall 36 cycles, single `hilo_we_o` pulse in cycle 37 with hi=2, lo=14.
- DIV −100/7 (0xFFFFFF9C, 7) -> hi=0xFFFFFFFE (−2), lo=0xFFFFFFF2 (−14).
- DIV 5/0 -> ready in cycle 4, `hilo_we_o` in cycle 5 with hi=0, lo=0, stall 4 cycles.
- `flush_i` in cycle 10 of a busy DIVU -> `div_start_o`=0 and `div_annul_o`=1 for cycles 11–13, no `hilo_we_o`. A DIV presented from cycle 11 stalls and is accepted in cycle 14, then returns the correct result.
- Back-to-back DIVU 9/2 then 9/4 -> two pulses (hi=1,lo=4), then (hi=1,lo=2); second start no earlier than 2 cycles after the first ready.
- `rst` asserted in cycle 20 of a division -> next cycle all outputs 0, state IDLE, no HI/LO write.
